// File: rtl/inst_rom_pkg.sv
`default_nettype none
// ============================================================================
// Module : inst_rom_pkg
// Brief  : Shared bus widths, reset polarity and loader state encoding.
// Rev    : 1.0
// ============================================================================
package inst_rom_pkg;

    localparam int          RegBus         = 32;
    localparam int          InstBus        = 32;
    localparam int          InstAddrBus    = 32;
    localparam logic        RstEnable      = 1'b1;
    localparam logic [31:0] ZeroWord       = 32'h0000_0000;
    localparam int          InstMemNumLog2 = 10;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/rom_byte_packer.sv
`default_nettype none
// ============================================================================
// Module : rom_byte_packer
// Brief  : Packs loader bytes big-endian into 32-bit words, zero-padding a
//          partial final word, and flags each completed word.
// Rev    : 1.0
// ============================================================================
module rom_byte_packer
    import inst_rom_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               accept,
    input  logic [7:0]         data,
    input  logic               last,
    output logic               word_valid,
    output logic [InstBus-1:0] word
);

    logic [1:0]         bcnt;
    logic [InstBus-1:0] shift_word;
    logic [InstBus-1:0] byte_lane;

    // Unfilled low lanes of shift_word are always zero, so OR-ing in the
    // current byte also yields the zero-padded word on an early last.
    always_comb begin
        byte_lane  = {data, 24'h00_0000} >> {bcnt, 3'b000};
        word       = shift_word | byte_lane;
        word_valid = accept & ((bcnt == 2'd3) | last);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt       <= 2'd0;
            shift_word <= '0;
        end else if (clear) begin
            bcnt       <= 2'd0;
            shift_word <= '0;
        end else if (accept) begin
            if (word_valid) begin
                bcnt       <= 2'd0;
                shift_word <= '0;
            end else begin
                bcnt       <= bcnt + 2'd1;
                shift_word <= word;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_rom.sv
`default_nettype none
// ============================================================================
// Module : inst_rom
// Brief  : Zero-latency instruction memory for the fetch port, filled by a
//          byte-stream loader that holds the core in reset until done.
// Rev    : 1.0
// ============================================================================
module inst_rom
    import inst_rom_pkg::*;
#(
    parameter int ADDR_W = InstMemNumLog2
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [InstAddrBus-1:0] addr,
    output logic [InstBus-1:0]     inst,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    input  logic [7:0]             ld_data,
    input  logic                   ld_last,
    output logic                   ld_ready,
    output logic                   ld_err,
    output logic                   core_rst_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    ld_state_t          state;
    logic [ADDR_W:0]    wptr;
    logic [InstBus-1:0] mem [DEPTH];

    logic               accept;
    logic               word_valid;
    logic [InstBus-1:0] word;
    logic               mem_we;
    logic [ADDR_W-1:0]  rd_idx;
    logic               addr_in_range;
    logic               unused_addr_lsb;

    // Start takes priority, so a byte offered in the same cycle is dropped.
    assign ld_ready = (state == ST_LOAD);
    assign accept   = ld_valid & ld_ready & ~ld_start;

    rom_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (ld_start),
        .accept     (accept),
        .data       (ld_data),
        .last       (ld_last),
        .word_valid (word_valid),
        .word       (word)
    );

    // wptr's top bit marks the saturated "memory full" position.
    assign mem_we = word_valid & ~wptr[ADDR_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_LOAD;
            wptr       <= '0;
            ld_err     <= 1'b0;
            core_rst_o <= RstEnable;
        end else if (ld_start) begin
            state      <= ST_LOAD;
            wptr       <= '0;
            ld_err     <= 1'b0;
            core_rst_o <= RstEnable;
        end else if (accept) begin
            if (word_valid) begin
                if (wptr[ADDR_W]) begin
                    ld_err <= 1'b1;
                end else begin
                    wptr <= wptr + 1'b1;
                end
            end
            if (ld_last) begin
                state      <= ST_RUN;
                core_rst_o <= ~RstEnable;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr[ADDR_W-1:0]] <= word;
        end
    end

    assign rd_idx          = addr[ADDR_W+1:2];
    assign addr_in_range   = (addr[InstAddrBus-1:ADDR_W+2] == '0);
    assign unused_addr_lsb = &{1'b0, addr[1:0]};

    always_comb begin
        inst = ZeroWord;
        if (ce && (state == ST_RUN) && addr_in_range) begin
            inst = mem[rd_idx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_rom.sv
`default_nettype none
// ============================================================================
// Module : tb_inst_rom
// Brief  : Scoreboard bench for inst_rom at ADDR_W=10 (dut_a) and ADDR_W=2
//          (dut_b) against an image-level reference model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_inst_rom;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_ce, a_start, a_valid, a_last, a_ready, a_err, a_crst;
    logic [31:0] a_addr, a_inst;
    logic [7:0]  a_data;
    logic        b_ce, b_start, b_valid, b_last, b_ready, b_err, b_crst;
    logic [31:0] b_addr, b_inst;
    logic [7:0]  b_data;

    inst_rom #(.ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst), .ce(a_ce), .addr(a_addr), .inst(a_inst),
        .ld_start(a_start), .ld_valid(a_valid), .ld_data(a_data), .ld_last(a_last),
        .ld_ready(a_ready), .ld_err(a_err), .core_rst_o(a_crst)
    );
    inst_rom #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .ce(b_ce), .addr(b_addr), .inst(b_inst),
        .ld_start(b_start), .ld_valid(b_valid), .ld_data(b_data), .ld_last(b_last),
        .ld_ready(b_ready), .ld_err(b_err), .core_rst_o(b_crst)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: memory image per DUT, run flag, highest word written.
    logic [31:0] ma [1024];
    logic [31:0] mb [4];
    bit          a_run = 0, b_run = 0;
    int          a_hw = 0, b_hw = 0;
    logic [7:0]  byte_q [$];
    logic [31:0] a_expq [$];
    logic [31:0] b_expq [$];
    bit          a_chk = 0, b_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_chk) begin
            if (a_expq.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_read_underflow actual=empty required=entry");
            end else check("a_read", a_inst, a_expq.pop_front());
        end
        if (b_chk) begin
            if (b_expq.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_read_underflow actual=empty required=entry");
            end else check("b_read", b_inst, b_expq.pop_front());
        end
    end

    function automatic logic ready_of(input bit sel); return sel ? b_ready : a_ready; endfunction
    function automatic logic crst_of(input bit sel);  return sel ? b_crst  : a_crst;  endfunction
    function automatic logic err_of(input bit sel);   return sel ? b_err   : a_err;   endfunction

    task automatic set_ld(input bit sel, input logic s, input logic v, input logic [7:0] d, input logic l);
        if (sel) begin b_start = s; b_valid = v; b_data = d; b_last = l; end
        else     begin a_start = s; a_valid = v; a_data = d; a_last = l; end
    endtask

    task automatic read(input bit sel, input logic [31:0] ad, input logic c);
        int          aw;
        logic [31:0] e;
        aw = sel ? 2 : 10;
        @(posedge clk); #1;
        e = 32'h0;
        if (c && (sel ? b_run : a_run) && ((ad >> (aw + 2)) == 0))
            e = sel ? mb[(ad >> 2) & 3] : ma[(ad >> 2) & 1023];
        if (sel) begin b_ce = c; b_addr = ad; b_chk = 1; b_expq.push_back(e); end
        else     begin a_ce = c; a_addr = ad; a_chk = 1; a_expq.push_back(e); end
        @(posedge clk); #1;
        if (sel) begin b_ce = 0; b_chk = 0; end else begin a_ce = 0; a_chk = 0; end
    endtask

    task automatic pulse_start(input bit sel);
        @(posedge clk); #1;
        set_ld(sel, 1, 0, 8'h00, 0);
        @(posedge clk); #1;
        set_ld(sel, 0, 0, 8'h00, 0);
        if (sel) b_run = 0; else a_run = 0;
        check("start_core_rst", {31'd0, crst_of(sel)}, 32'd1);
        check("start_ready",    {31'd0, ready_of(sel)}, 32'd1);
        check("start_err_clr",  {31'd0, err_of(sel)}, 32'd0);
    endtask

    // Streams byte_q as one image (ld_last on the final byte), then updates the model.
    task automatic load(input bit sel, input bit with_start);
        int          n, nwords, depth;
        logic [31:0] w;
        n = byte_q.size();
        depth = sel ? 4 : 1024;
        if (with_start) pulse_start(sel);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                set_ld(sel, 0, 0, 8'h00, 0);
                @(posedge clk); #1;
            end
            set_ld(sel, 0, 1, byte_q[i], (i == n - 1));
            if (!ready_of(sel)) begin
                checks++; failures++;
                $display("FAIL load_ready actual=0 required=1 byte=%0d", i);
            end
            if (i == n - 1) check("core_rst_before_last", {31'd0, crst_of(sel)}, 32'd1);
            @(posedge clk); #1;
        end
        set_ld(sel, 0, 0, 8'h00, 0);
        nwords = (n + 3) / 4;
        check("core_rst_after_last", {31'd0, crst_of(sel)}, 32'd0);
        check("ready_in_run",        {31'd0, ready_of(sel)}, 32'd0);
        check("ld_err_after_load",   {31'd0, err_of(sel)}, {31'd0, nwords > depth});
        for (int wi = 0; wi < nwords && wi < depth; wi++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++)
                if (4 * wi + k < n) w = w | ({24'h0, byte_q[4 * wi + k]} << (24 - 8 * k));
            if (sel) mb[wi] = w; else ma[wi] = w;
        end
        if (sel) begin b_run = 1; if (nwords > b_hw) b_hw = (nwords > 4) ? 4 : nwords; end
        else     begin a_run = 1; if (nwords > a_hw) a_hw = nwords; end
    endtask

    task automatic rand_image(input int n);
        byte_q.delete();
        for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0;
        a_ce = 0; a_addr = 0; b_ce = 0; b_addr = 0;
        set_ld(0, 0, 0, 8'h00, 0);
        set_ld(1, 0, 0, 8'h00, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready",    {31'd0, a_ready}, 32'd1);
        check("reset_core_rst", {31'd0, a_crst}, 32'd1);
        check("reset_err",      {31'd0, a_err}, 32'd0);
        check("reset_inst",     a_inst, 32'd0);
        rst = 1;
        read(0, 32'h0, 1);

        // Two-word program.
        byte_q = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
        load(0, 0);
        read(0, 32'h4, 1);
        read(0, 32'h0, 1);

        // Partial final word is zero padded.
        byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        load(0, 1);
        read(0, 32'h4, 1);
        read(0, 32'h4, 0);
        read(0, 32'h0000_1000, 1);
        read(0, 32'h0000_0006, 1);

        // Loader inputs are ignored while running.
        @(posedge clk); #1;
        set_ld(0, 0, 1, 8'h5A, 1);
        repeat (3) @(posedge clk);
        #1;
        check("run_ignores_ready", {31'd0, a_ready}, 32'd0);
        check("run_ignores_crst",  {31'd0, a_crst}, 32'd0);
        set_ld(0, 0, 0, 8'h00, 0);
        read(0, 32'h0, 1);
        read(0, 32'h4, 1);

        // Randomised images and reads.
        for (int it = 0; it < 6; it++) begin
            rand_image($urandom_range(1, 40));
            load(0, 1);
            for (int r = 0; r < 8; r++) begin
                logic [31:0] ad;
                if ($urandom_range(0, 3) == 0) ad = $urandom | 32'h0000_1000;
                else ad = ($urandom_range(0, a_hw - 1) << 2) | $urandom_range(0, 3);
                read(0, ad, ($urandom_range(0, 4) != 0));
            end
        end

        // Start during a mid-word byte restarts the load and drops that byte.
        pulse_start(0);
        @(posedge clk); #1;
        set_ld(0, 0, 1, 8'h11, 0);
        @(posedge clk); #1;
        set_ld(0, 0, 1, 8'h22, 0);
        @(posedge clk); #1;
        set_ld(0, 1, 1, 8'h77, 0);
        @(posedge clk); #1;
        set_ld(0, 0, 0, 8'h00, 0);
        byte_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
        load(0, 0);
        read(0, 32'h0, 1);
        read(0, 32'h4, 1);

        // Depth-4 instance: overflow, exact fit, partial overflow.
        rand_image(20);
        load(1, 0);
        for (int i = 0; i < 4; i++) read(1, i * 4, 1);
        read(1, 32'h10, 1);
        rand_image(16);
        load(1, 1);
        for (int i = 0; i < 4; i++) read(1, i * 4 + 2, 1);
        rand_image(17);
        load(1, 1);
        read(1, 32'hC, 1);

        // Asynchronous reset mid-load.
        pulse_start(0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            set_ld(0, 0, 1, 8'($urandom), 0);
        end
        @(negedge clk);
        #1;
        rst = 0;
        #1;
        check("async_a_ready",    {31'd0, a_ready}, 32'd1);
        check("async_a_core_rst", {31'd0, a_crst}, 32'd1);
        check("async_b_core_rst", {31'd0, b_crst}, 32'd1);
        check("async_b_err",      {31'd0, b_err}, 32'd0);
        check("async_b_ready",    {31'd0, b_ready}, 32'd1);
        set_ld(0, 0, 0, 8'h00, 0);
        a_run = 0; b_run = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        read(0, 32'h0, 1);
        rand_image(8);
        load(0, 0);
        read(0, 32'h0, 1);
        read(0, 32'h4, 1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
